threshold_binarize: RTL and testbench
=====================================

# threshold_binarize

Pixel-stream binarization stage placed directly upstream of the 3x3 morphological erosion stage. It converts each grey-level pixel to a pure background or foreground value (all-ones / all-zeros), so the erosion window sees only two levels. The threshold is either a fixed software value or an adaptive per-frame mean. The mean is computed from the previous frame by a serial divider and applied at the next frame boundary.

## Interface
- IMAGE_WIDTH, 320, pixels per line
- IMAGE_HEIGHT, 464, lines per frame
- DATA_WIDTH, 8, pixel width
- BACKGROUND_COLOR, 1, 1: background = all-ones, foreground (dark) = all-zeros; 0: inverted
- INIT_THRESH, 128, adaptive threshold after reset
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset; one clock, reset asynchronous active-low
- pixel_valid  in  1  pixel_in qualifier; no backpressure
- pixel_in  in  DATA_WIDTH  grey pixel, raster order
- thresh_mode  in  1  0 = fixed_thresh, 1 = adaptive mean; sampled per accepted pixel
- fixed_thresh  in  DATA_WIDTH  fixed threshold
- pixel_out_valid  out  1  output qualifier
- pixel_out  out  DATA_WIDTH  binarized pixel
- cur_thresh  out  DATA_WIDTH  threshold used for the most recent output pixel
- frame_done  out  1  one-cycle pulse coincident with the output of the last pixel of a frame
- div_overrun  out  1  sticky; set when a frame ends while the divider is busy

## Operation
- Raster counters col (0..IMAGE_WIDTH-1) and row (0..IMAGE_HEIGHT-1) advance on each accepted pixel. col wraps to 0 and increments row; row wraps to 0 after IMAGE_HEIGHT-1.
- Compare: if pixel_in < T, output the foreground value; otherwise output the background value. Foreground is all-zeros when BACKGROUND_COLOR=1 and all-ones when BACKGROUND_COLOR=0.
- T = fixed_thresh when thresh_mode=0, else T = effective adaptive threshold.
- Adaptive threshold registers:
  - active_thr, reset INIT_THRESH.
  - pending_thr with pending_vld, reset 0.
  - Effective adaptive threshold = pending_thr when pending_vld and the pixel is at (0,0); otherwise active_thr.
  - At the (0,0) accept with pending_vld set: active_thr <= pending_thr and pending_vld is cleared, regardless of thresh_mode.
- Accumulator:
  - sum width SUM_BITS = DATA_WIDTH + clog2(IMAGE_WIDTH*IMAGE_HEIGHT).
  - Every accepted pixel is added to sum regardless of mode.
  - On the last pixel (col=W-1, row=H-1), sum+pixel_in is captured into the divider dividend, and sum clears to 0 in the same cycle.
- Divider FSM:
  - States: IDLE -> DIV -> DONE -> IDLE.
  - IDLE: a captured last pixel moves the FSM to DIV.
  - DIV: restoring division by the constant IMAGE_WIDTH*IMAGE_HEIGHT, one quotient bit per cycle, exactly SUM_BITS cycles, quotient floored.
  - DONE (one cycle): pending_thr <= quotient[DATA_WIDTH-1:0], pending_vld <= 1. If pending_vld is already set, it is overwritten.
- Overrun: if a last pixel arrives while the FSM is in DIV or DONE, that frame's mean is discarded and div_overrun is set. The running division continues, and sum still clears.
- Reset, including mid-frame: counters, sum, FSM (returns to IDLE), pending_vld and div_overrun all clear; active_thr <= INIT_THRESH.

## Timing
- Latency is 1 cycle: a pixel accepted at cycle t appears with pixel_out_valid=1 at t+1. Gaps in pixel_valid pass through unchanged.
- Reset values of outputs:
  - pixel_out_valid=0
  - pixel_out = background value
  - cur_thresh = INIT_THRESH
  - frame_done=0
  - div_overrun=0
- pixel_out and cur_thresh hold their values while pixel_out_valid=0.
- frame_done is high in the same cycle as the output of pixel (W-1,H-1).
- Last pixel accepted at t: DIV spans cycles t+1..t+SUM_BITS, DONE is at t+SUM_BITS+1, and pending_vld is visible from t+SUM_BITS+2.
- If the next frame's (0,0) pixel is accepted before t+SUM_BITS+2, that whole frame uses the old active_thr. The new value is applied at the following frame start.

## Test plan
- Fixed mode, W=4, H=2, BACKGROUND_COLOR=1, fixed_thresh=100; input 99,100,0,255 … -> outputs 0,255,0,255 …, each 1 cycle after input; frame_done pulses with the 8th output.
- Adaptive, W=4, H=2: frame 1 = 10,20,…,80 (sum 360). Idle for 14 cycles, then frame 2 = 44,45,46,0,255,45,44,90 -> frame 1 compares against 128 (all 0); frame 2 uses 45: 0,255,255,0,255,255,0,255; cur_thresh=45.
- Back-to-back frames, W=4, H=2 (SUM_BITS=11 > 8): frame 2 uses 128 and its own mean is dropped with div_overrun=1; frame 3 uses frame 1's mean.
- BACKGROUND_COLOR=0, fixed_thresh=50; inputs 49,50 -> 255,0.
- Reset asserted mid-DIV and mid-frame -> outputs return to reset values immediately. Next frame counts from (0,0) with threshold 128, and no stale pending_thr is applied.
- pixel_valid toggling every other cycle over a full frame -> output count equals input count, and frame_done fires exactly once.

Source files
------------

// File: rtl/threshold_binarize.sv
// threshold_binarize
//   Converts a raster stream of grey pixels to a two-level image for the
//   downstream erosion stage. Each accepted pixel below the threshold becomes
//   the foreground value and every other pixel becomes the background value.
//   The threshold is either fixed_thresh or an adaptive per-frame mean. A
//   serial restoring divider produces that mean from the previous frame, and
//   it takes effect at the next frame start.
//
// Ports
//   clk             clock
//   rst_n           asynchronous active-low reset
//   pixel_valid     pixel_in qualifier (no backpressure)
//   pixel_in        grey pixel, raster order
//   thresh_mode     0 = fixed_thresh, 1 = adaptive mean
//   fixed_thresh    fixed threshold
//   pixel_out_valid output qualifier, one cycle after the accept
//   pixel_out       binarized pixel (held while pixel_out_valid = 0)
//   cur_thresh      threshold used for the most recent output pixel
//   frame_done      pulse with the output of the last pixel of a frame
//   div_overrun     sticky: a frame ended while the divider was still busy
module threshold_binarize #(
    parameter int IMAGE_WIDTH      = 320,
    parameter int IMAGE_HEIGHT     = 464,
    parameter int DATA_WIDTH       = 8,
    parameter int BACKGROUND_COLOR = 1,
    parameter int INIT_THRESH      = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pixel_valid,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  thresh_mode,
    input  logic [DATA_WIDTH-1:0] fixed_thresh,
    output logic                  pixel_out_valid,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic [DATA_WIDTH-1:0] cur_thresh,
    output logic                  frame_done,
    output logic                  div_overrun
);

    localparam int PIX      = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int SUM_BITS = DATA_WIDTH + $clog2(PIX);
    localparam int COL_W    = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CNT_W    = $clog2(SUM_BITS);

    localparam logic [SUM_BITS:0]     DIVISOR  = (SUM_BITS+1)'(PIX);
    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SUM_BITS - 1);
    localparam logic [DATA_WIDTH-1:0] BG_VAL   = (BACKGROUND_COLOR != 0) ?
                                                 {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] FG_VAL   = ~BG_VAL;
    localparam logic [DATA_WIDTH-1:0] INIT_VAL = DATA_WIDTH'(INIT_THRESH);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [SUM_BITS-1:0]   sum_q;
    logic [SUM_BITS-1:0]   quo_q;
    logic [SUM_BITS-1:0]   rem_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] active_thr_q, pending_thr_q;
    logic                  pending_vld_q;
    logic                  valid_q, fd_q, ovr_q;
    logic [DATA_WIDTH-1:0] pix_q, thr_q;

    logic                  is_first, is_last, capture, overrun_hit, apply_pending;
    logic [DATA_WIDTH-1:0] adapt_thr, thr;
    logic [SUM_BITS-1:0]   sum_total;
    logic [SUM_BITS:0]     rem_shift, diff;
    logic                  q_bit;

    assign is_first  = (col_q == '0) && (row_q == '0);
    assign is_last   = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign sum_total = sum_q + SUM_BITS'(pixel_in);

    // A freshly computed mean is used by the (0,0) pixel that promotes it.
    assign apply_pending = pixel_valid && is_first && pending_vld_q;
    assign adapt_thr     = (is_first && pending_vld_q) ? pending_thr_q : active_thr_q;
    assign thr           = thresh_mode ? adapt_thr : fixed_thresh;

    assign capture     = pixel_valid && is_last && (state_q == IDLE);
    assign overrun_hit = pixel_valid && is_last && (state_q != IDLE);

    // Restoring division step. The partial remainder is always below DIVISOR,
    // so the shifted value is below 2*DIVISOR and the borrow (MSB of diff)
    // alone tells whether the subtraction fits.
    assign rem_shift = {rem_q, quo_q[SUM_BITS-1]};
    assign diff      = rem_shift - DIVISOR;
    assign q_bit     = ~diff[SUM_BITS];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pixel_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = DIV;
            DIV:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            sum_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            active_thr_q  <= INIT_VAL;
            pending_thr_q <= '0;
            pending_vld_q <= 1'b0;
            valid_q       <= 1'b0;
            fd_q          <= 1'b0;
            ovr_q         <= 1'b0;
            pix_q         <= BG_VAL;
            thr_q         <= INIT_VAL;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;

            if (pixel_valid) begin
                sum_q <= is_last ? '0 : sum_total;
            end

            case (state_q)
                IDLE: begin
                    if (capture) begin
                        quo_q <= sum_total;
                        rem_q <= '0;
                        cnt_q <= '0;
                    end
                end
                DIV: begin
                    quo_q <= {quo_q[SUM_BITS-2:0], q_bit};
                    rem_q <= q_bit ? diff[SUM_BITS-1:0] : rem_shift[SUM_BITS-1:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase

            // A mean completing in DONE wins over a same-cycle promotion.
            if (apply_pending) begin
                active_thr_q <= pending_thr_q;
            end
            if (state_q == DONE) begin
                pending_thr_q <= quo_q[DATA_WIDTH-1:0];
                pending_vld_q <= 1'b1;
            end else if (apply_pending) begin
                pending_vld_q <= 1'b0;
            end

            if (overrun_hit) begin
                ovr_q <= 1'b1;
            end

            valid_q <= pixel_valid;
            fd_q    <= pixel_valid && is_last;
            if (pixel_valid) begin
                pix_q <= (pixel_in < thr) ? FG_VAL : BG_VAL;
                thr_q <= thr;
            end
        end
    end

    assign pixel_out_valid = valid_q;
    assign pixel_out       = pix_q;
    assign cur_thresh      = thr_q;
    assign frame_done      = fd_q;
    assign div_overrun     = ovr_q;

endmodule

// File: tb/tb_threshold_binarize.sv
module tb_threshold_binarize;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int SB = 8 + $clog2(W * H);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pixel_valid = 1'b0;
    logic [7:0] pixel_in = 8'd0;
    logic       thresh_mode = 1'b0;
    logic [7:0] fixed_thresh = 8'd0;
    logic       pixel_out_valid;
    logic [7:0] pixel_out;
    logic [7:0] cur_thresh;
    logic       frame_done;
    logic       div_overrun;

    logic       b_valid = 1'b0;
    logic [7:0] b_pix = 8'd0;
    logic       b_out_valid;
    logic [7:0] b_out;
    logic [7:0] b_thr;
    logic       b_fd;
    logic       b_ovr;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    threshold_binarize #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8),
        .BACKGROUND_COLOR(1), .INIT_THRESH(128)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
        .thresh_mode(thresh_mode), .fixed_thresh(fixed_thresh),
        .pixel_out_valid(pixel_out_valid), .pixel_out(pixel_out),
        .cur_thresh(cur_thresh), .frame_done(frame_done), .div_overrun(div_overrun)
    );

    threshold_binarize #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8),
        .BACKGROUND_COLOR(0), .INIT_THRESH(128)
    ) dut_inv (
        .clk(clk), .rst_n(rst_n), .pixel_valid(b_valid), .pixel_in(b_pix),
        .thresh_mode(1'b0), .fixed_thresh(8'd50),
        .pixel_out_valid(b_out_valid), .pixel_out(b_out),
        .cur_thresh(b_thr), .frame_done(b_fd), .div_overrun(b_ovr)
    );

    task automatic check(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endtask

    // Frame-level reference: timestamps say when a mean becomes visible and
    // how long the divider stays busy after a frame's last pixel.
    longint k = 0;
    int     m_col, m_row, m_act, m_pv, sch_val;
    longint m_sum, sch_at, busy_until;
    bit     m_pvld, sch_has, m_ovr;
    int     e_vld, e_pix, e_thr, e_fd;

    // Log of DUT outputs for literal checks by the stimulus.
    int outs[$];
    int thrs[$];
    int fd_cnt = 0;
    int fd_idx = 0;

    always @(negedge clk) begin
        int first, last, eff, t;
        k++;
        if (!rst_n) begin
            m_col = 0; m_row = 0; m_sum = 0; m_act = 128; m_pv = 0; m_pvld = 0;
            sch_has = 0; sch_val = 0; sch_at = 0; busy_until = -100; m_ovr = 0;
            e_vld = 0; e_pix = 255; e_thr = 128; e_fd = 0;
        end
        check("vld", int'(pixel_out_valid), e_vld);
        check("pix", int'(pixel_out), e_pix);
        check("thr", int'(cur_thresh), e_thr);
        check("fd",  int'(frame_done), e_fd);
        check("ovr", int'(div_overrun), int'(m_ovr));
        if (pixel_out_valid) begin
            outs.push_back(int'(pixel_out));
            thrs.push_back(int'(cur_thresh));
            if (frame_done) begin
                fd_cnt++;
                fd_idx = outs.size();
            end
        end
        if (rst_n) begin
            if (sch_has && k >= sch_at) begin
                m_pv = sch_val; m_pvld = 1; sch_has = 0;
            end
            if (pixel_valid) begin
                first = (m_col == 0 && m_row == 0);
                last  = (m_col == W-1 && m_row == H-1);
                eff   = (first && m_pvld) ? m_pv : m_act;
                if (first && m_pvld) begin
                    m_act = m_pv; m_pvld = 0;
                end
                t = thresh_mode ? eff : int'(fixed_thresh);
                e_vld = 1;
                e_pix = (int'(pixel_in) < t) ? 0 : 255;
                e_thr = t;
                e_fd  = last;
                m_sum += pixel_in;
                if (last) begin
                    if (k <= busy_until) m_ovr = 1;
                    else begin
                        sch_val = int'(m_sum / (W * H));
                        sch_at = k + SB + 2; sch_has = 1; busy_until = k + SB + 1;
                    end
                    m_sum = 0;
                end
                if (m_col == W-1) begin
                    m_col = 0;
                    m_row = (m_row == H-1) ? 0 : m_row + 1;
                end else m_col++;
            end else begin
                e_vld = 0; e_fd = 0;
            end
        end
    end

    task automatic px(input int p);
        pixel_valid = 1'b1; pixel_in = 8'(p);
        @(posedge clk); #1;
        pixel_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int v[8]);
        for (int i = 0; i < 8; i++) px(v[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        outs.delete(); thrs.delete(); fd_cnt = 0; fd_idx = 0;
    endtask

    task automatic check_seq(input string name, input int base, input int v[8]);
        for (int i = 0; i < 8; i++) check(name, outs[base + i], v[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int f_in[8], f_exp[8], a1[8], a2[8], a2_exp[8], zeros[8];
        int c_in[8], c_exp[8], r_in[8], r_exp[8];
        zeros = '{0, 0, 0, 0, 0, 0, 0, 0};
        repeat (2) @(posedge clk); #1;

        // Reset state
        check("rst_vld", int'(pixel_out_valid), 0);
        check("rst_pix", int'(pixel_out), 255);
        check("rst_thr", int'(cur_thresh), 128);
        check("rst_inv_pix", int'(b_out), 0);
        rst_n = 1'b1;

        // Fixed threshold 100
        do_reset();
        thresh_mode = 1'b0; fixed_thresh = 8'd100;
        f_in  = '{99, 100, 0, 255, 99, 100, 0, 255};
        f_exp = '{0, 255, 0, 255, 0, 255, 0, 255};
        frame(f_in); idle(2);
        check("fixed_cnt", outs.size(), 8);
        check_seq("fixed_out", 0, f_exp);
        check("fixed_fd_cnt", fd_cnt, 1);
        check("fixed_fd_idx", fd_idx, 8);
        check("fixed_thr", thrs[7], 100);

        // Adaptive: mean of frame 1 (360/8 = 45) applied to frame 2
        do_reset();
        thresh_mode = 1'b1;
        a1 = '{10, 20, 30, 40, 50, 60, 70, 80};
        a2 = '{44, 45, 46, 0, 255, 45, 44, 90};
        a2_exp = '{0, 255, 255, 0, 255, 255, 0, 255};
        frame(a1); idle(14); frame(a2); idle(2);
        check("adp_cnt", outs.size(), 16);
        check_seq("adp_f1", 0, zeros);
        check("adp_f1_thr", thrs[0], 128);
        check_seq("adp_f2", 8, a2_exp);
        check("adp_f2_thr", thrs[15], 45);
        check("adp_ovr", int'(div_overrun), 0);

        // Back-to-back: frame B too early (128) and overruns; C uses A's mean 100
        do_reset();
        thresh_mode = 1'b1;
        frame('{100, 100, 100, 100, 100, 100, 100, 100});
        frame('{127, 128, 0, 255, 127, 128, 0, 255});
        check("b2b_ovr", int'(div_overrun), 1);
        idle(8);
        c_in  = '{99, 100, 101, 0, 255, 100, 99, 100};
        c_exp = '{0, 255, 255, 0, 255, 255, 0, 255};
        frame(c_in); idle(2);
        check_seq("b2b_fB", 8, '{0, 255, 0, 255, 0, 255, 0, 255});
        check("b2b_fB_thr", thrs[15], 128);
        check_seq("b2b_fC", 16, c_exp);
        check("b2b_fC_thr", thrs[23], 100);
        check("b2b_fd_cnt", fd_cnt, 3);

        // Inverted background, fixed 50
        b_valid = 1'b1; b_pix = 8'd49;
        @(posedge clk); #1;
        check("inv_49", int'(b_out), 255);
        b_pix = 8'd50;
        @(posedge clk); #1;
        b_valid = 1'b0;
        check("inv_50", int'(b_out), 0);
        check("inv_thr", int'(b_thr), 50);

        // Reset mid-DIV and mid-frame: no stale mean (200) may survive
        do_reset();
        thresh_mode = 1'b1;
        frame('{200, 200, 200, 200, 200, 200, 200, 200});
        idle(3); px(1); px(1);
        rst_n = 1'b0; #1;
        check("mid_rst_vld", int'(pixel_out_valid), 0);
        check("mid_rst_pix", int'(pixel_out), 255);
        check("mid_rst_thr", int'(cur_thresh), 128);
        check("mid_rst_fd", int'(frame_done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(20);
        outs.delete(); thrs.delete(); fd_cnt = 0; fd_idx = 0;
        r_in  = '{127, 128, 0, 255, 10, 200, 127, 128};
        r_exp = '{0, 255, 0, 255, 0, 255, 0, 255};
        frame(r_in); idle(2);
        check_seq("mid_rst_out", 0, r_exp);
        check("mid_rst_thr2", thrs[7], 128);
        check("mid_rst_fd_idx", fd_idx, 8);

        // pixel_valid toggling every other cycle
        do_reset();
        thresh_mode = 1'b0; fixed_thresh = 8'd100;
        for (int i = 0; i < 8; i++) begin
            px((i % 2 == 0) ? 0 : 200);
            idle(1);
        end
        idle(2);
        check("tog_cnt", outs.size(), 8);
        check("tog_fd_cnt", fd_cnt, 1);
        check_seq("tog_out", 0, '{0, 255, 0, 255, 0, 255, 0, 255});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
